// File: rtl/uart_fetch_bridge.sv
// Fetches a 16-bit instruction over a byte UART link. It sends the fetch opcode and
// the address, then receives the high byte and the low byte.
module uart_fetch_bridge #(
    parameter logic [7:0]  CMD_FETCH      = 8'h03,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  address,
    input  logic        stop_for_rw,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        tx_done,
    output logic        tx_start_out,
    output logic [7:0]  tx_data_out,
    output logic [15:0] instruction_out,
    output logic        done_out,
    output logic        busy,
    output logic        error_out
);

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, WAIT_CMD, SEND_ADDR, WAIT_ADDR, RX_HI, RX_LO, DONE
    } state_t;

    state_t      state;
    logic [15:0] timer;
    logic [7:0]  addr_q;
    logic [7:0]  hi_byte;
    logic [7:0]  lo_byte;
    logic        timeout_hit;

    // The counter would reach TIMEOUT_CYCLES-1 on this edge, so the wait ends here.
    assign timeout_hit = (timer == TIMEOUT_CYCLES - 16'd2);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            addr_q          <= '0;
            hi_byte         <= '0;
            lo_byte         <= '0;
            tx_start_out    <= 1'b0;
            tx_data_out     <= '0;
            instruction_out <= '0;
            done_out        <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make each pulse output last one cycle and clear
            // the timer on every state change. A later assignment in the case overrides them.
            tx_start_out <= 1'b0;
            done_out     <= 1'b0;
            error_out    <= 1'b0;
            timer        <= '0;

            case (state)
                IDLE: begin
                    if (start && !stop_for_rw) begin
                        addr_q       <= address;
                        state        <= SEND_CMD;
                        tx_start_out <= 1'b1;
                        tx_data_out  <= CMD_FETCH;
                    end
                end
                SEND_CMD:  state <= stop_for_rw ? IDLE : WAIT_CMD;
                WAIT_CMD: begin
                    if (stop_for_rw) begin
                        state <= IDLE;
                    end else if (tx_done) begin
                        state        <= SEND_ADDR;
                        tx_start_out <= 1'b1;
                        tx_data_out  <= addr_q;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        error_out <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                SEND_ADDR: state <= stop_for_rw ? IDLE : WAIT_ADDR;
                WAIT_ADDR: begin
                    if (stop_for_rw) begin
                        state <= IDLE;
                    end else if (tx_done) begin
                        state <= RX_HI;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        error_out <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RX_HI: begin
                    if (stop_for_rw) begin
                        state <= IDLE;
                    end else if (rx_done) begin
                        hi_byte <= rx_data;
                        state   <= RX_LO;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        error_out <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RX_LO: begin
                    if (stop_for_rw) begin
                        state <= IDLE;
                    end else if (rx_done) begin
                        lo_byte         <= rx_data;
                        instruction_out <= {hi_byte, rx_data};
                        done_out        <= 1'b1;
                        state           <= DONE;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        error_out <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DONE:      state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fetch_bridge.sv
// Directed bench for uart_fetch_bridge. It runs table-driven fetches, then hand-written
// sequences for abort, timeout, coincident events and mid-fetch reset.
module tb_uart_fetch_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  address;
    logic        stop_for_rw;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        tx_done;
    logic        tx_start_out;
    logic [7:0]  tx_data_out;
    logic [15:0] instruction_out;
    logic        done_out;
    logic        busy;
    logic        error_out;

    int passed = 0;
    int total  = 0;

    uart_fetch_bridge #(.CMD_FETCH(8'h03), .TIMEOUT_CYCLES(16'd20)) dut (
        .clk(clk), .reset(reset), .start(start), .address(address),
        .stop_for_rw(stop_for_rw), .rx_done(rx_done), .rx_data(rx_data),
        .tx_done(tx_done), .tx_start_out(tx_start_out), .tx_data_out(tx_data_out),
        .instruction_out(instruction_out), .done_out(done_out), .busy(busy),
        .error_out(error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] instr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        rx_done = 1'b1;
        rx_data = d;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // Starts a fetch and returns at the first negedge inside RX_HI.
    task automatic go_to_rx_hi(input logic [7:0] a);
        start = 1'b1; address = a;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        pulse_tx_done();
        @(negedge clk);
        pulse_tx_done();
    endtask

    task automatic do_fetch(input vec_t v, input string tag);
        start = 1'b1; address = v.addr;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_cmd_start"}, tx_start_out, 1'b1);
        check({tag, "_cmd_byte"}, tx_data_out, 8'h03);
        @(negedge clk);
        check({tag, "_cmd_start_once"}, tx_start_out, 1'b0);
        check({tag, "_cmd_hold"}, tx_data_out, 8'h03);
        cycles(3);
        pulse_tx_done();
        check({tag, "_addr_start"}, tx_start_out, 1'b1);
        check({tag, "_addr_byte"}, tx_data_out, v.addr);
        @(negedge clk);
        cycles(2);
        pulse_tx_done();
        cycles(2);
        pulse_rx(v.hi);
        check({tag, "_no_early_done"}, done_out, 1'b0);
        cycles(1);
        pulse_rx(v.lo);
        check({tag, "_done"}, done_out, 1'b1);
        check({tag, "_instr"}, instruction_out, v.instr);
        @(negedge clk);
        check({tag, "_done_once"}, done_out, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_instr_hold"}, instruction_out, v.instr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        vec_t v;
        logic early_err;

        vecs[0] = '{8'h00, 8'hFF, 8'hFF, 16'hFFFF};
        vecs[1] = '{8'hFF, 8'h00, 8'h00, 16'h0000};
        vecs[2] = '{8'h81, 8'h12, 8'h34, 16'h1234};
        vecs[3] = '{8'h2A, 8'hBE, 8'hEF, 16'hBEEF};

        reset = 1'b1; start = 1'b0; address = '0; stop_for_rw = 1'b0;
        rx_done = 1'b0; rx_data = '0; tx_done = 1'b0;
        cycles(2);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_start", tx_start_out, 1'b0);
        check("rst_tx_data", tx_data_out, 8'h00);
        check("rst_instr", instruction_out, 16'h0000);
        check("rst_done", done_out, 1'b0);
        check("rst_error", error_out, 1'b0);
        reset = 1'b0;
        cycles(1);

        for (int i = 0; i < 4; i++) do_fetch(vecs[i], $sformatf("vec%0d", i));

        // A start is ignored while the core owns the UART.
        stop_for_rw = 1'b1; start = 1'b1; address = 8'h44;
        @(negedge clk);
        start = 1'b0;
        check("blocked_busy", busy, 1'b0);
        check("blocked_tx", tx_start_out, 1'b0);
        stop_for_rw = 1'b0;
        cycles(1);

        // Abort in RX_LO after the high byte arrives.
        go_to_rx_hi(8'h10);
        pulse_rx(8'h12);
        check("abort_pre_busy", busy, 1'b1);
        stop_for_rw = 1'b1;
        @(negedge clk);
        stop_for_rw = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done_out, 1'b0);
        check("abort_error", error_out, 1'b0);
        check("abort_instr", instruction_out, 16'hBEEF);
        cycles(3);
        check("abort_no_late_done", done_out, 1'b0);
        check("abort_instr_hold", instruction_out, 16'hBEEF);

        // Timeout in WAIT_CMD: error arrives 19 cycles after entry.
        start = 1'b1; address = 8'h55;
        @(negedge clk);
        start = 1'b0;
        early_err = 1'b0;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (error_out || !busy) early_err = 1'b1;
        end
        check("to_no_early_error", early_err, 1'b0);
        @(negedge clk);
        check("to_error", error_out, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_instr", instruction_out, 16'hBEEF);
        @(negedge clk);
        check("to_error_once", error_out, 1'b0);

        // Ignored inputs: a start while busy, and a stray rx_done in WAIT_ADDR.
        start = 1'b1; address = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; address = 8'h77;
        @(negedge clk);
        start = 1'b0;
        check("ign_no_restart", tx_start_out, 1'b0);
        pulse_tx_done();
        check("ign_addr_byte", tx_data_out, 8'h3C);
        @(negedge clk);
        pulse_rx(8'hAA);
        check("ign_stray_rx_busy", busy, 1'b1);
        pulse_tx_done();
        pulse_rx(8'h56);
        pulse_rx(8'h78);
        check("ign_done", done_out, 1'b1);
        check("ign_instr", instruction_out, 16'h5678);
        cycles(1);

        // rx_done on the timeout cycle of RX_HI: the byte wins.
        go_to_rx_hi(8'h20);
        cycles(18);
        pulse_rx(8'h9A);
        check("coin_rx_no_error", error_out, 1'b0);
        check("coin_rx_busy", busy, 1'b1);
        pulse_rx(8'hBC);
        check("coin_rx_done", done_out, 1'b1);
        check("coin_rx_instr", instruction_out, 16'h9ABC);
        cycles(1);

        // stop_for_rw together with tx_done: the abort wins.
        start = 1'b1; address = 8'h21;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        stop_for_rw = 1'b1;
        pulse_tx_done();
        stop_for_rw = 1'b0;
        check("coin_stop_busy", busy, 1'b0);
        check("coin_stop_tx", tx_start_out, 1'b0);
        check("coin_stop_error", error_out, 1'b0);
        check("coin_stop_instr", instruction_out, 16'h9ABC);
        cycles(1);

        // Reset during WAIT_ADDR clears everything at once; the next fetch works.
        start = 1'b1; address = 8'h05;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        pulse_tx_done();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mrst_busy", busy, 1'b0);
        check("mrst_tx_data", tx_data_out, 8'h00);
        check("mrst_instr", instruction_out, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        cycles(3);
        check("mrst_no_done", done_out, 1'b0);
        check("mrst_idle", busy, 1'b0);
        v = '{8'h05, 8'h00, 8'h01, 16'h0001};
        do_fetch(v, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_fetch_bridge.md
UART_FETCH_BRIDGE -- requirements
Module: uart_fetch_bridge

Interface
REQ-001 Parameter CMD_FETCH, default 8'h03, is the request opcode byte sent to the host before the address.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd50000, is the maximum number of cycles spent in any wait state.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to fetch the instruction at address.
REQ-006 address  input  8  PC value, sampled on an accepted start.
REQ-007 stop_for_rw  input  1  high while the core owns the UART; blocks or aborts a fetch.
REQ-008 rx_done  input  1  one-cycle pulse; rx_data valid this cycle.
REQ-009 rx_data  input  8  received byte.
REQ-010 tx_done  input  1  one-cycle pulse; the transmitter finished the current byte.
REQ-011 tx_start_out  output  1  one-cycle pulse; the transmitter sends tx_data_out.
REQ-012 tx_data_out  output  8  byte to transmit.
REQ-013 instruction_out  output  16  last successfully fetched instruction.
REQ-014 done_out  output  1  one-cycle pulse; instruction_out is newly valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 error_out  output  1  one-cycle pulse on timeout.

Function
REQ-017 The FSM SHALL have the states IDLE, SEND_CMD, WAIT_CMD, SEND_ADDR, WAIT_ADDR, RX_HI, RX_LO and DONE.
REQ-018 IDLE: start=1 with stop_for_rw=0 -> latch address and go to SEND_CMD; start is ignored while stop_for_rw=1.
REQ-019 SEND_CMD: tx_start_out=1 and tx_data_out=CMD_FETCH for exactly one cycle; go to WAIT_CMD.
REQ-020 WAIT_CMD: tx_done=1 -> SEND_ADDR.
REQ-021 SEND_ADDR: tx_start_out=1 and tx_data_out=latched address for one cycle; go to WAIT_ADDR.
REQ-022 WAIT_ADDR: tx_done=1 -> RX_HI.
REQ-023 RX_HI: rx_done=1 -> capture rx_data as bits [15:8] and go to RX_LO.
REQ-024 RX_LO: rx_done=1 -> capture rx_data as bits [7:0] and go to DONE.
REQ-025 DONE: instruction_out={hi,lo} updates on entry, done_out=1 for this single cycle, then go to IDLE; latency from the rx_done of the low byte to done_out is 1 cycle.
REQ-026 instruction_out SHALL change only on entry to DONE and holds its value otherwise, including across aborts and timeouts.
REQ-027 tx_data_out SHALL hold the last driven byte when tx_start_out=0.
REQ-028 rx_done is ignored outside RX_HI/RX_LO; tx_done is ignored outside WAIT_CMD/WAIT_ADDR; start is ignored when not in IDLE.
REQ-029 stop_for_rw=1 in any non-IDLE state except DONE SHALL abort to IDLE next cycle, with no done_out, no error_out and instruction_out unchanged.
REQ-030 A 16-bit timeout counter SHALL clear on every state change and increment each cycle in WAIT_CMD, WAIT_ADDR, RX_HI and RX_LO.
REQ-031 When the counter reaches TIMEOUT_CYCLES-1 with no qualifying event, the FSM goes to IDLE and error_out pulses for 1 cycle.
REQ-032 If a qualifying event coincides with the timeout cycle, the event wins and no error is raised.
REQ-033 If stop_for_rw and a qualifying event coincide, the abort wins.

Reset
REQ-034 Asynchronous reset SHALL force: state=IDLE, tx_start_out=0, tx_data_out=8'h00, instruction_out=16'h0000, done_out=0, busy=0, error_out=0, timeout counter=0, latched address and byte registers=0.
REQ-035 Reset asserted mid-fetch SHALL abandon the transfer, with no done_out after release.
REQ-036 The first start after release SHALL be accepted normally.

Verification
REQ-037 Normal fetch: start with address=8'h2A -> tx bytes 8'h03 then 8'h2A, each a one-cycle tx_start_out; rx 8'hBE, 8'hEF -> instruction_out=16'hBEEF and done_out pulses 1 cycle after the second rx_done.
REQ-038 Abort: stop_for_rw=1 while in RX_LO after hi=8'h12 -> IDLE, no done_out, instruction_out keeps its prior value 16'hBEEF.
REQ-039 Timeout: TIMEOUT_CYCLES=16'd20, no tx_done after the command -> error_out pulse 19 cycles after entering WAIT_CMD, then busy=0.
REQ-040 Ignored inputs: start pulsed while busy, and a stray rx_done in WAIT_ADDR -> the sequence is unchanged and the result is correct.
REQ-041 Coincident events: rx_done on the timeout cycle in RX_HI -> the byte is captured, no error_out; stop_for_rw with tx_done -> abort.
REQ-042 Mid-fetch reset: reset asserted in WAIT_ADDR -> all outputs at reset values immediately; a subsequent fetch of 8'h05 returning 8'h00,8'h01 gives 16'h0001.
